// File: rtl/pipelined_csa_prefix_adder.sv
// ---------------------------------------------------------------------------
// pipelined_csa_prefix_adder
//
// Three-stage streaming three-operand adder: out_sum = a + b + c + cin.
// The result is exact (WIDTH+2 bits). Each transaction selects signed
// (two's complement) or unsigned operands.
//   S1: sign/zero extension and 3:2 carry-save compression. The compressed
//       sum/carry pair is registered as propagate/generate vectors.
//   S2: Ladner-Fischer parallel-prefix carry network. It registers the
//       group carries G[i:0].
//   S3: final xor. This register drives out_sum/out_tag directly.
// Flow control is an elastic valid/ready chain. A stage loads whenever it is
// empty or its downstream stage is able to move, so bubbles collapse under
// backpressure. in_ready is combinational from out_ready.
//
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   in_valid/in_ready  input handshake
//   in_a/in_b/in_c     WIDTH-bit operands
//   in_cin             carry-in (weight 1)
//   in_signed          1 = operands are two's complement
//   in_tag             sideband tag, returned with the result
//   out_valid/out_ready output handshake
//   out_sum            WIDTH+2-bit exact sum
//   out_tag            tag of the result
// ---------------------------------------------------------------------------
module pipelined_csa_prefix_adder #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [WIDTH-1:0]   in_c,
    input  logic               in_cin,
    input  logic               in_signed,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH+1:0]   out_sum,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int EW   = WIDTH + 2;
    localparam int LVLS = $clog2(EW);

    // Two extra bits are enough: three extended operands plus cin always fit.
    function automatic logic [EW-1:0] extend(input logic [WIDTH-1:0] v, input logic sgn);
        logic [1:0] top;
        if (sgn && v[WIDTH-1]) begin
            top = 2'b11;
        end else begin
            top = 2'b00;
        end
        return {top, v};
    endfunction

    // Stage registers
    logic               v1_r, v2_r, v3_r;
    logic [EW-1:0]      p1_r, g1_r;
    logic [TAG_W-1:0]   tag1_r, tag2_r, tag3_r;
    logic [EW-1:0]      p2_r, x2_r;
    logic [EW-1:0]      sum3_r;

    // Combinational intermediates
    logic               r1_s, r2_s, r3_s;
    logic [EW-1:0]      a_x_s, b_x_s, c_x_s;
    logic [EW-1:0]      s1_s, c1_s, cs_s;
    logic [EW-1:0]      p_in_s, g_in_s;
    logic [EW-1:0]      gl_s [0:LVLS];
    logic [EW-1:0]      pl_s [0:LVLS];
    logic [EW-1:0]      sum_s;

    // A stage can load when it is empty or its contents move on this edge.
    assign r3_s     = !v3_r | out_ready;
    assign r2_s     = !v2_r | r3_s;
    assign r1_s     = !v1_r | r2_s;
    assign in_ready = r1_s;

    assign out_valid = v3_r;
    assign out_sum   = sum3_r;
    assign out_tag   = tag3_r;

    // Extension and 3:2 compression. cin occupies the empty bit 0 of the
    // shifted carry vector, so S2 needs no separate carry input.
    always_comb begin
        a_x_s  = extend(in_a, in_signed);
        b_x_s  = extend(in_b, in_signed);
        c_x_s  = extend(in_c, in_signed);
        s1_s   = a_x_s ^ b_x_s ^ c_x_s;
        c1_s   = (a_x_s & b_x_s) | (a_x_s & c_x_s) | (b_x_s & c_x_s);
        cs_s   = {c1_s[EW-2:0], in_cin};
        p_in_s = s1_s ^ cs_s;
        g_in_s = s1_s & cs_s;
    end

    // Ladner-Fischer prefix network. At level l, every bit whose index has
    // bit l set merges with the top bit of the preceding 2^l block. After
    // LVLS levels, each node spans down to bit 0.
    always_comb begin
        for (int l = 0; l <= LVLS; l++) begin
            gl_s[l] = '0;
            pl_s[l] = '0;
        end
        gl_s[0] = g1_r;
        pl_s[0] = p1_r;
        for (int l = 0; l < LVLS; l++) begin
            for (int i = 0; i < EW; i++) begin
                if (((i >> l) & 1) == 1) begin
                    gl_s[l+1][i] = gl_s[l][i] | (pl_s[l][i] & gl_s[l][((i >> l) << l) - 1]);
                    pl_s[l+1][i] = pl_s[l][i] & pl_s[l][((i >> l) << l) - 1];
                end else begin
                    gl_s[l+1][i] = gl_s[l][i];
                    pl_s[l+1][i] = pl_s[l][i];
                end
            end
        end
    end

    // The carry into bit i is the group carry of bits i-1..0.
    always_comb begin
        sum_s = p2_r ^ {x2_r[EW-2:0], 1'b0};
    end

    // Stage 1 register: propagate/generate of the compressed pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_r   <= 1'b0;
            p1_r   <= '0;
            g1_r   <= '0;
            tag1_r <= '0;
        end else if (r1_s) begin
            v1_r   <= in_valid;
            p1_r   <= p_in_s;
            g1_r   <= g_in_s;
            tag1_r <= in_tag;
        end
    end

    // Stage 2 register: group carries and propagate.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2_r   <= 1'b0;
            p2_r   <= '0;
            x2_r   <= '0;
            tag2_r <= '0;
        end else if (r2_s) begin
            v2_r   <= v1_r;
            p2_r   <= p1_r;
            x2_r   <= gl_s[LVLS];
            tag2_r <= tag1_r;
        end
    end

    // Stage 3 register: the output register. It holds while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            v3_r   <= 1'b0;
            sum3_r <= '0;
            tag3_r <= '0;
        end else if (r3_s) begin
            v3_r   <= v2_r;
            sum3_r <= sum_s;
            tag3_r <= tag2_r;
        end
    end

endmodule

// File: tb/tb_pipelined_csa_prefix_adder.sv
module tb_pipelined_csa_prefix_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // 32-bit instance
    logic        iv32, ir32, cin32, sg32, ov32, or32;
    logic [31:0] a32, b32, c32;
    logic [3:0]  tg32, otag32;
    logic [33:0] osum32;

    // 8-bit instance
    logic        iv8, ir8, cin8, sg8, ov8, or8;
    logic [7:0]  a8, b8, c8;
    logic [3:0]  tg8, otag8;
    logic [9:0]  osum8;

    pipelined_csa_prefix_adder #(.WIDTH(32), .TAG_W(4)) dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32),
        .in_a(a32), .in_b(b32), .in_c(c32), .in_cin(cin32), .in_signed(sg32),
        .in_tag(tg32), .out_valid(ov32), .out_ready(or32),
        .out_sum(osum32), .out_tag(otag32)
    );

    pipelined_csa_prefix_adder #(.WIDTH(8), .TAG_W(4)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
        .in_a(a8), .in_b(b8), .in_c(c8), .in_cin(cin8), .in_signed(sg8),
        .in_tag(tg8), .out_valid(ov8), .out_ready(or8),
        .out_sum(osum8), .out_tag(otag8)
    );

    int nchk = 0;
    int nerr = 0;
    int xfer32 = 0;
    int xfer8 = 0;
    logic acc32, acc8, ir32_seen;

    logic [33:0] q_sum32 [$];
    logic [3:0]  q_tag32 [$];
    logic [9:0]  q_sum8  [$];
    logic [3:0]  q_tag8  [$];

    // Reference: exact integer sum of the operand values, reduced to W+2 bits.
    function automatic logic [33:0] model32(input logic [31:0] a, b, c, input logic cin, sgn);
        longint ea, eb, ec, tot;
        ea  = sgn ? longint'($signed(a)) : longint'(a);
        eb  = sgn ? longint'($signed(b)) : longint'(b);
        ec  = sgn ? longint'($signed(c)) : longint'(c);
        tot = ea + eb + ec + longint'(cin);
        return tot[33:0];
    endfunction

    function automatic logic [9:0] model8(input logic [7:0] a, b, c, input logic cin, sgn);
        longint ea, eb, ec, tot;
        ea  = sgn ? longint'($signed(a)) : longint'(a);
        eb  = sgn ? longint'($signed(b)) : longint'(b);
        ec  = sgn ? longint'($signed(c)) : longint'(c);
        tot = ea + eb + ec + longint'(cin);
        return tot[9:0];
    endfunction

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 5))
            0: return 32'hFFFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'h7FFF_FFFF;
            3: return 32'h0000_0000;
            default: return 32'($urandom);
        endcase
    endfunction

    function automatic logic [7:0] pick8();
        case ($urandom_range(0, 5))
            0: return 8'hFF;
            1: return 8'h80;
            2: return 8'h7F;
            3: return 8'h00;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load_rand32();
        a32 = pick32(); b32 = pick32(); c32 = pick32();
        cin32 = 1'($urandom); sg32 = 1'($urandom); tg32 = 4'($urandom);
    endtask

    task automatic load_rand8();
        a8 = pick8(); b8 = pick8(); c8 = pick8();
        cin8 = 1'($urandom); sg8 = 1'($urandom); tg8 = 4'($urandom);
    endtask

    // One clock: settle inputs, score both handshakes, advance to next negedge.
    task automatic step();
        logic [33:0] es32;
        logic [9:0]  es8;
        logic [3:0]  et;
        #1;
        acc32 = iv32 && ir32;
        acc8  = iv8 && ir8;
        ir32_seen = ir32;
        if (acc32) begin
            q_sum32.push_back(model32(a32, b32, c32, cin32, sg32));
            q_tag32.push_back(tg32);
        end
        if (acc8) begin
            q_sum8.push_back(model8(a8, b8, c8, cin8, sg8));
            q_tag8.push_back(tg8);
        end
        if (ov32 && or32) begin
            xfer32++;
            if (q_sum32.size() == 0) begin
                check("spurious_out32_qdepth", 64'(q_sum32.size()), 64'd1);
            end else begin
                es32 = q_sum32.pop_front();
                et   = q_tag32.pop_front();
                check("sum32", 64'(osum32), 64'(es32));
                check("tag32", 64'(otag32), 64'(et));
            end
        end
        if (ov8 && or8) begin
            xfer8++;
            if (q_sum8.size() == 0) begin
                check("spurious_out8_qdepth", 64'(q_sum8.size()), 64'd1);
            end else begin
                es8 = q_sum8.pop_front();
                et  = q_tag8.pop_front();
                check("sum8", 64'(osum8), 64'(es8));
                check("tag8", 64'(otag8), 64'(et));
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int idx;
        logic [33:0] hold_sum;
        logic [3:0]  hold_tag;
        logic [31:0] bpa [6];
        logic [31:0] bpb [6];
        logic [31:0] bpc [6];
        logic [3:0]  bpt [6];
        logic        bps [6];

        rst = 1'b1;
        iv32 = 1'b0; a32 = '0; b32 = '0; c32 = '0; cin32 = 1'b0; sg32 = 1'b0; tg32 = '0;
        iv8 = 1'b0; a8 = '0; b8 = '0; c8 = '0; cin8 = 1'b0; sg8 = 1'b0; tg8 = '0;
        or32 = 1'b0; or8 = 1'b1;
        hold_sum = '0; hold_tag = '0;
        @(negedge clk);
        step();
        step();
        rst = 1'b0;
        #1;
        check("reset_out_valid", 64'(ov32), 64'd0);
        check("reset_out_sum", 64'(osum32), 64'd0);
        check("reset_out_tag", 64'(otag32), 64'd0);
        check("reset_in_ready", 64'(ir32), 64'd1);
        check("reset_out_valid8", 64'(ov8), 64'd0);

        // Unsigned maximum, latency of exactly 3 cycles.
        or32 = 1'b1;
        iv32 = 1'b1; a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF; c32 = 32'hFFFF_FFFF;
        cin32 = 1'b1; sg32 = 1'b0; tg32 = 4'd5;
        step();
        check("lat_accept", 64'(acc32), 64'd1);
        iv32 = 1'b0;
        check("lat_cycle1", 64'(ov32), 64'd0);
        step();
        check("lat_cycle2", 64'(ov32), 64'd0);
        step();
        check("lat_cycle3", 64'(ov32), 64'd1);
        check("umax_sum", 64'(osum32), 64'h2_FFFF_FFFE);
        check("umax_tag", 64'(otag32), 64'd5);
        step();

        // Signed minimum, then signed -1-1-1+1.
        iv32 = 1'b1; sg32 = 1'b1;
        a32 = 32'h8000_0000; b32 = 32'h8000_0000; c32 = 32'h8000_0000; cin32 = 1'b0; tg32 = 4'd1;
        step();
        a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF; c32 = 32'hFFFF_FFFF; cin32 = 1'b1; tg32 = 4'd2;
        step();
        iv32 = 1'b0;
        step();
        check("smin_valid", 64'(ov32), 64'd1);
        check("smin_sum", 64'(osum32), 64'h2_8000_0000);
        check("smin_tag", 64'(otag32), 64'd1);
        step();
        check("sneg2_sum", 64'(osum32), 64'h3_FFFF_FFFE);
        check("sneg2_tag", 64'(otag32), 64'd2);
        step();

        // 20 back-to-back mixed-mode transactions.
        c0 = xfer32;
        for (int k = 0; k < 23; k++) begin
            if (k < 20) begin
                iv32 = 1'b1;
                load_rand32();
            end else begin
                iv32 = 1'b0;
            end
            step();
            if (k < 20) check("b2b_accept", 64'(acc32), 64'd1);
            check("b2b_out_count", 64'(xfer32 - c0), 64'((k < 3) ? 0 : ((k - 2 > 20) ? 20 : k - 2)));
        end

        // Backpressure: 6 transactions, 5 stalled cycles.
        for (int k = 0; k < 6; k++) begin
            bpa[k] = pick32(); bpb[k] = pick32(); bpc[k] = pick32();
            bpt[k] = 4'(k + 8); bps[k] = 1'($urandom);
        end
        or32 = 1'b0;
        idx = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            iv32 = 1'b1;
            a32 = bpa[idx]; b32 = bpb[idx]; c32 = bpc[idx];
            tg32 = bpt[idx]; sg32 = bps[idx]; cin32 = 1'(idx);
            step();
            check("bp_in_ready", 64'(ir32_seen), 64'(cyc < 3));
            if (acc32) idx++;
            if (cyc >= 2) begin
                check("bp_hold_valid", 64'(ov32), 64'd1);
                if (cyc == 2) begin
                    hold_sum = osum32;
                    hold_tag = otag32;
                end else begin
                    check("bp_hold_sum", 64'(osum32), 64'(hold_sum));
                    check("bp_hold_tag", 64'(otag32), 64'(hold_tag));
                end
            end
        end
        check("bp_accepted_while_stalled", 64'(idx), 64'd3);
        or32 = 1'b1;
        for (int k = 0; k < 20 && idx < 6; k++) begin
            iv32 = 1'b1;
            a32 = bpa[idx]; b32 = bpb[idx]; c32 = bpc[idx];
            tg32 = bpt[idx]; sg32 = bps[idx]; cin32 = 1'(idx);
            step();
            if (acc32) idx++;
        end
        iv32 = 1'b0;
        check("bp_all_accepted", 64'(idx), 64'd6);
        for (int k = 0; k < 20 && q_sum32.size() > 0; k++) step();
        check("bp_drained", 64'(q_sum32.size()), 64'd0);

        // Reset with three transactions in flight.
        or32 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            iv32 = 1'b1;
            load_rand32();
            step();
        end
        iv32 = 1'b0;
        or32 = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        q_sum32.delete();
        q_tag32.delete();
        #1;
        check("midrst_out_valid", 64'(ov32), 64'd0);
        check("midrst_out_sum", 64'(osum32), 64'd0);
        check("midrst_in_ready", 64'(ir32), 64'd1);
        or32 = 1'b1;
        c0 = xfer32;
        for (int k = 0; k < 6; k++) step();
        check("midrst_no_ghost", 64'(xfer32 - c0), 64'd0);

        // Random soak on both widths.
        for (int cyc = 0; cyc < 10000; cyc++) begin
            iv32 = 1'($urandom); load_rand32(); or32 = 1'($urandom);
            iv8  = 1'($urandom); load_rand8();  or8  = 1'($urandom);
            step();
        end
        iv32 = 1'b0; iv8 = 1'b0; or32 = 1'b1; or8 = 1'b1;
        for (int k = 0; k < 20 && (q_sum32.size() > 0 || q_sum8.size() > 0); k++) step();
        check("soak32_drained", 64'(q_sum32.size()), 64'd0);
        check("soak8_drained", 64'(q_sum8.size()), 64'd0);
        check("soak8_activity", 64'(xfer8 > 1000), 64'd1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/pipelined_csa_prefix_adder.md
Name: pipelined_csa_prefix_adder

Overview:
Parametrised, pipelined three-operand adder computing a+b+c+cin to full precision. It performs a carry-save compression, then a Ladner-Fischer parallel-prefix carry network, then the final sum. It is the streaming successor of the fixed 32-bit combinational three-operand adder and feeds the approximate-multiplier partial-product accumulation path. It adds width parametrisation, a per-transaction signed/unsigned mode, a pass-through tag, and valid/ready flow control with backpressure.

Parameters:
WIDTH, 32, operand width in bits (>=4); result width is WIDTH+2
TAG_W, 4, width of the sideband tag carried alongside each transaction

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  input transaction present
in_ready  output  1  block can accept the input this cycle
in_a  input  WIDTH  operand a
in_b  input  WIDTH  operand b
in_c  input  WIDTH  operand c
in_cin  input  1  carry-in, weight 1
in_signed  input  1  1 = operands are two's complement; 0 = unsigned
in_tag  input  TAG_W  sideband tag, returned unchanged with the result
out_valid  output  1  result present
out_ready  input  1  downstream accepts the result
out_sum  output  WIDTH+2  exact a+b+c+cin, two's complement if signed
out_tag  output  TAG_W  tag of the result

Behaviour:
- Reset: on a clk edge with rst=1, all stage valids clear. out_valid=0, out_sum=0, out_tag=0. Internal data registers are zeroed. Reset mid-operation discards every in-flight transaction; no partial result is emitted afterwards.
- Transfer rules: an input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- Stage 1 (S1 register):
  - Sign- or zero-extend a, b, c to WIDTH+2 according to in_signed.
  - Per-bit 3:2 compression gives s1 = a^b^c and c1 = maj(a,b,c).
  - Register p = s1 ^ (c1<<1 with cin in bit 0) and g = s1 & (c1<<1 with cin), plus tag and valid.
- Stage 2 (S2 register):
  - Ladner-Fischer prefix network over WIDTH+2 bits, ceil(log2(WIDTH+2)) levels.
  - Output is the group carries x[i] = G[i:0].
  - Register x, p, tag and valid.
- Stage 3 (S3 register = outputs):
  - sum[0] = p[0]; sum[i] = p[i] ^ x[i-1] for i >= 1.
  - Register into out_sum and out_tag; out_valid is the S3 valid.
- Latency: exactly 3 cycles from input transfer to out_valid when there is no backpressure. Throughput is 1 result per cycle.
- Flow control (elastic, bubble-collapsing):
  - r3 = !v3 | out_ready
  - r2 = !v2 | r3
  - r1 = !v1 | r2
  - in_ready = r1
  - Stage k loads from stage k-1 when rk=1, and its valid takes the upstream valid.
  - When rk=0, stage k holds its data and valid unchanged.
  - in_ready combinationally depends on out_ready; this path is accepted.
- While out_valid=1 and out_ready=0, out_sum and out_tag are stable.
- Ordering is strictly FIFO; no transaction is dropped or duplicated. At most 3 transactions are in flight.
- Width rules:
  - The result is exact with no overflow in either mode.
  - Unsigned maximum: 3(2^W-1)+1 < 2^(W+2).
  - Signed minimum: -3*2^(W-1) >= -2^(W+1).
  - Signed maximum: 3(2^(W-1)-1)+1 < 2^(W+1).
- Mode is carried per transaction, so mixed signed and unsigned back-to-back inputs must each be correct.
- in_valid=0 inserts a bubble. Bubbles collapse under backpressure.

Test Plan:
- WIDTH=32, unsigned, a=b=c=0xFFFFFFFF, cin=1, tag=5, out_ready=1 -> out_valid exactly 3 cycles later, out_sum=0x2FFFFFFFE, out_tag=5.
- Signed, a=b=c=0x80000000, cin=0 -> out_sum=0x280000000 (-3*2^31); then signed a=b=c=0xFFFFFFFF, cin=1 -> 0x3FFFFFFFE (-2).
- Back-to-back: 20 random mixed-mode transactions on consecutive cycles with out_ready=1 -> 20 results on consecutive cycles, in order, each matching the reference model.
- Backpressure: stream 6 transactions, hold out_ready=0 for 5 cycles.
  - in_ready drops after 3 are accepted.
  - out_sum/out_tag stay stable while stalled.
  - All 6 are delivered in order after release with no loss.
- Reset mid-flight: 3 transactions in flight, assert rst one cycle -> next cycle out_valid=0, out_sum=0, in_ready=1, and none of the 3 results ever appears.
- Random soak, WIDTH=8 and WIDTH=32, random in_valid/out_ready (50%) for 10k cycles -> scoreboard match, zero mismatches, FIFO order preserved.
